// File: rtl/vmem_xlat_requester.sv
// Load/store MMU translation requester: splits one vector memory command at page
// boundaries, translates each page through the MMU and hands out physical chunks.

package vmem_xlat_pkg;
  localparam int unsigned XLEN = 64;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  localparam logic [XLEN-1:0] LOAD_PAGE_FAULT  = 64'd13;
  localparam logic [XLEN-1:0] STORE_PAGE_FAULT = 64'd15;
endpackage

module vmem_xlat_requester
  import vmem_xlat_pkg::*;
#(
  parameter int unsigned VLEN      = 64,
  parameter int unsigned PLEN      = 56,
  parameter int unsigned PAGE_BITS = 12,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_ld_st_translation_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [VLEN-1:0]      cmd_vaddr_i,
  input  logic [31:0]          cmd_len_i,
  input  logic                 cmd_is_store_i,
  output logic                 mmu_req_o,
  output logic [VLEN-1:0]      mmu_vaddr_o,
  output logic                 mmu_is_store_o,
  input  logic                 mmu_valid_i,
  input  logic [PLEN-1:0]      mmu_paddr_i,
  input  exception_t           mmu_exception_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PLEN-1:0]      out_paddr_o,
  output logic [PAGE_BITS:0]   out_bytes_o,
  output logic                 out_last_o,
  output logic                 ex_valid_o,
  output exception_t           ex_o,
  output logic                 timeout_o
);

  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned CHUNK_W = PAGE_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EMIT,
    S_EXCPT
  } state_e;

  state_e           state_q, state_d;
  logic [VLEN-1:0]  cur_vaddr_q, cur_vaddr_d;
  logic [31:0]      rem_q, rem_d;
  logic             is_store_q, is_store_d;
  logic [PLEN-1:0]  paddr_q, paddr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  exception_t       ex_q, ex_d;

  // Bytes left in the current page, 1..2^PAGE_BITS; one extra bit holds a full page.
  logic [CHUNK_W-1:0] page_room;
  logic [31:0]        room_ext;
  logic [31:0]        chunk_len;
  logic               chunk_last;

  assign page_room  = {1'b1, {PAGE_BITS{1'b0}}} - {1'b0, cur_vaddr_q[PAGE_BITS-1:0]};
  assign room_ext   = 32'(page_room);
  assign chunk_len  = (rem_q < room_ext) ? rem_q : room_ext;
  assign chunk_last = (chunk_len == rem_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cur_vaddr_q <= '0;
      rem_q       <= '0;
      is_store_q  <= 1'b0;
      paddr_q     <= '0;
      wait_cnt_q  <= '0;
      ex_q        <= '0;
    end else begin
      state_q     <= state_d;
      cur_vaddr_q <= cur_vaddr_d;
      rem_q       <= rem_d;
      is_store_q  <= is_store_d;
      paddr_q     <= paddr_d;
      wait_cnt_q  <= wait_cnt_d;
      ex_q        <= ex_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cur_vaddr_d = cur_vaddr_q;
    rem_d       = rem_q;
    is_store_d  = is_store_q;
    paddr_d     = paddr_q;
    wait_cnt_d  = wait_cnt_q;
    ex_d        = ex_q;
    cmd_ready_o = 1'b0;
    mmu_req_o   = 1'b0;
    out_valid_o = 1'b0;
    ex_valid_o  = 1'b0;
    timeout_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          ex_d = '0;
          if (cmd_len_i != 32'd0) begin
            cur_vaddr_d = cmd_vaddr_i;
            rem_d       = cmd_len_i;
            is_store_d  = cmd_is_store_i;
            state_d     = S_REQ;
          end
        end
      end

      S_REQ: begin
        wait_cnt_d = '0;
        if (en_ld_st_translation_i) begin
          mmu_req_o = 1'b1;
          state_d   = S_WAIT;
        end else begin
          paddr_d = cur_vaddr_q[PLEN-1:0];
          state_d = S_EMIT;
        end
      end

      S_WAIT: begin
        // A response on the final counted cycle still wins over the timeout.
        if (mmu_valid_i) begin
          if (mmu_exception_i.valid) begin
            ex_d    = mmu_exception_i;
            state_d = S_EXCPT;
          end else begin
            paddr_d = mmu_paddr_i;
            state_d = S_EMIT;
          end
        end else if (wait_cnt_q == CNT_LAST) begin
          timeout_o = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_EMIT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (chunk_last) begin
            state_d = S_IDLE;
          end else begin
            cur_vaddr_d = cur_vaddr_q + VLEN'(chunk_len);
            rem_d       = rem_q - chunk_len;
            state_d     = S_REQ;
          end
        end
      end

      S_EXCPT: begin
        ex_valid_o = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Payloads are zeroed outside their valid window so idle outputs read as 0.
  assign mmu_vaddr_o    = mmu_req_o ? cur_vaddr_q : '0;
  assign mmu_is_store_o = mmu_req_o & is_store_q;
  assign out_paddr_o    = out_valid_o ? paddr_q : '0;
  assign out_bytes_o    = out_valid_o ? chunk_len[CHUNK_W-1:0] : '0;
  assign out_last_o     = out_valid_o & chunk_last;
  assign ex_o           = ex_q;

endmodule

// File: tb/tb_vmem_xlat_requester.sv
// Directed bench for vmem_xlat_requester: page splitting, stalls, faults, timeout,
// translation bypass, address wrap and asynchronous reset.

module tb_vmem_xlat_requester;
  import vmem_xlat_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             en_xlat;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [63:0]      cmd_vaddr;
  logic [31:0]      cmd_len;
  logic             cmd_is_store;
  logic             mmu_req;
  logic [63:0]      mmu_vaddr;
  logic             mmu_is_store;
  logic             mmu_valid;
  logic [55:0]      mmu_paddr;
  exception_t       mmu_exception;
  logic             out_valid;
  logic             out_ready;
  logic [55:0]      out_paddr;
  logic [12:0]      out_bytes;
  logic             out_last;
  logic             ex_valid;
  exception_t       ex;
  logic             timeout;

  int total = 0;
  int bad   = 0;
  int req_count = 0;

  vmem_xlat_requester dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .en_ld_st_translation_i (en_xlat),
    .cmd_valid_i            (cmd_valid),
    .cmd_ready_o            (cmd_ready),
    .cmd_vaddr_i            (cmd_vaddr),
    .cmd_len_i              (cmd_len),
    .cmd_is_store_i         (cmd_is_store),
    .mmu_req_o              (mmu_req),
    .mmu_vaddr_o            (mmu_vaddr),
    .mmu_is_store_o         (mmu_is_store),
    .mmu_valid_i            (mmu_valid),
    .mmu_paddr_i            (mmu_paddr),
    .mmu_exception_i        (mmu_exception),
    .out_valid_o            (out_valid),
    .out_ready_i            (out_ready),
    .out_paddr_o            (out_paddr),
    .out_bytes_o            (out_bytes),
    .out_last_o             (out_last),
    .ex_valid_o             (ex_valid),
    .ex_o                   (ex),
    .timeout_o              (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mmu_req === 1'b1) req_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [63:0] vaddr, input logic [31:0] len, input logic store,
                          input logic xlat);
    @(negedge clk);
    en_xlat      = xlat;
    cmd_valid    = 1'b1;
    cmd_vaddr    = vaddr;
    cmd_len      = len;
    cmd_is_store = store;
    #1 check("cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic expect_req(input string tag, input logic [63:0] vaddr, input logic store);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (mmu_req) break;
    end
    check({tag, "_req"}, mmu_req, 1'b1);
    check({tag, "_vaddr"}, mmu_vaddr, vaddr);
    check({tag, "_store"}, mmu_is_store, store);
  endtask

  task automatic mmu_respond(input int lat, input logic [55:0] paddr, input logic exc_v,
                             input logic [63:0] cause, input logic [63:0] tval);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) check("req_single_pulse", mmu_req, 1'b0);
    end
    mmu_valid           = 1'b1;
    mmu_paddr           = paddr;
    mmu_exception.valid = exc_v;
    mmu_exception.cause = cause;
    mmu_exception.tval  = tval;
    @(posedge clk);
    #1;
    mmu_valid     = 1'b0;
    mmu_exception = '0;
  endtask

  task automatic expect_chunk(input string tag, input logic [55:0] paddr, input logic [12:0] bytes,
                              input logic last, input int stall);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) break;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_paddr"}, out_paddr, paddr);
    check({tag, "_bytes"}, out_bytes, bytes);
    check({tag, "_last"}, out_last, last);
    check({tag, "_no_req"}, mmu_req, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      check({tag, "_stall_valid"}, out_valid, 1'b1);
      check({tag, "_stall_paddr"}, out_paddr, paddr);
      check({tag, "_stall_bytes"}, out_bytes, bytes);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_idle_ready"}, cmd_ready, 1'b1);
    check({tag, "_idle_out"}, out_valid, 1'b0);
  endtask

  initial begin
    int  req_before;
    bit  early;

    rst_n         = 1'b0;
    en_xlat       = 1'b1;
    cmd_valid     = 1'b0;
    cmd_vaddr     = '0;
    cmd_len       = '0;
    cmd_is_store  = 1'b0;
    mmu_valid     = 1'b0;
    mmu_paddr     = '0;
    mmu_exception = '0;
    out_ready     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_mmu_req", mmu_req, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_bytes", out_bytes, 13'd0);
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex", ex, '0);
    check("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;

    // T1: single chunk inside one page
    req_before = req_count;
    send_cmd(64'h1000, 32'd16, 1'b0, 1'b1);
    expect_req("t1", 64'h1000, 1'b0);
    mmu_respond(1, 56'h8000_1000, 1'b0, '0, '0);
    expect_chunk("t1_c0", 56'h8000_1000, 13'd16, 1'b1, 0);
    expect_idle("t1");
    check("t1_req_count", req_count - req_before, 1);

    // T2: store crossing a page, 8 + 16 bytes
    send_cmd(64'h1FF8, 32'd24, 1'b1, 1'b1);
    expect_req("t2_r0", 64'h1FF8, 1'b1);
    mmu_respond(1, 56'hABC_FF8, 1'b0, '0, '0);
    expect_chunk("t2_c0", 56'hABC_FF8, 13'd8, 1'b0, 0);
    expect_req("t2_r1", 64'h2000, 1'b1);
    mmu_respond(2, 56'h777_000, 1'b0, '0, '0);
    expect_chunk("t2_c1", 56'h777_000, 13'd16, 1'b1, 0);
    expect_idle("t2");

    // T3: two full pages with downstream stalls and slower MMU
    send_cmd(64'h0, 32'h2000, 1'b0, 1'b1);
    expect_req("t3_r0", 64'h0, 1'b0);
    mmu_respond(3, 56'h10_0000, 1'b0, '0, '0);
    expect_chunk("t3_c0", 56'h10_0000, 13'd4096, 1'b0, 5);
    expect_req("t3_r1", 64'h1000, 1'b0);
    mmu_respond(1, 56'h20_0000, 1'b0, '0, '0);
    expect_chunk("t3_c1", 56'h20_0000, 13'd4096, 1'b1, 5);
    expect_idle("t3");

    // T4: second page faults on a store
    send_cmd(64'h1FF0, 32'h20, 1'b1, 1'b1);
    expect_req("t4_r0", 64'h1FF0, 1'b1);
    mmu_respond(1, 56'h9FF0, 1'b0, '0, '0);
    expect_chunk("t4_c0", 56'h9FF0, 13'd16, 1'b0, 0);
    expect_req("t4_r1", 64'h2000, 1'b1);
    mmu_respond(1, 56'h0, 1'b1, STORE_PAGE_FAULT, 64'h2000);
    @(negedge clk);
    #1;
    check("t4_ex_valid", ex_valid, 1'b1);
    check("t4_ex_cause", ex.cause, STORE_PAGE_FAULT);
    check("t4_ex_tval", ex.tval, 64'h2000);
    check("t4_ex_flag", ex.valid, 1'b1);
    check("t4_no_out", out_valid, 1'b0);
    @(negedge clk);
    #1;
    check("t4_ex_pulse_end", ex_valid, 1'b0);
    check("t4_back_idle", cmd_ready, 1'b1);
    check("t4_ex_held", ex.cause, STORE_PAGE_FAULT);

    // T5: MMU never answers
    send_cmd(64'h5000, 32'd4, 1'b0, 1'b1);
    expect_req("t5", 64'h5000, 1'b0);
    check("t5_ex_cleared", ex.valid, 1'b0);
    early = 1'b0;
    for (int c = 1; c < 1024; c++) begin
      @(negedge clk);
      #1;
      if (timeout || mmu_req || cmd_ready) early = 1'b1;
    end
    check("t5_no_early_timeout", early, 1'b0);
    @(negedge clk);
    #1;
    check("t5_timeout", timeout, 1'b1);
    check("t5_busy_at_timeout", cmd_ready, 1'b0);
    @(negedge clk);
    #1;
    check("t5_timeout_pulse_end", timeout, 1'b0);
    check("t5_ready_after", cmd_ready, 1'b1);

    // Stray MMU response while idle must be ignored
    mmu_valid           = 1'b1;
    mmu_exception.valid = 1'b1;
    mmu_exception.cause = LOAD_PAGE_FAULT;
    @(posedge clk);
    #1;
    mmu_valid     = 1'b0;
    mmu_exception = '0;
    @(negedge clk);
    #1;
    check("stray_ex_valid", ex_valid, 1'b0);
    check("stray_ex", ex.valid, 1'b0);
    check("stray_ready", cmd_ready, 1'b1);

    // Zero-length command: accepted, nothing emitted
    req_before = req_count;
    send_cmd(64'h1234, 32'd0, 1'b0, 1'b1);
    expect_idle("len0");
    check("len0_no_req", req_count - req_before, 0);

    // T6: translation off across a page
    req_before = req_count;
    send_cmd(64'h3FFC, 32'd8, 1'b0, 1'b0);
    expect_chunk("t6_c0", 56'h3FFC, 13'd4, 1'b0, 0);
    expect_chunk("t6_c1", 56'h4000, 13'd4, 1'b1, 0);
    expect_idle("t6");
    check("t6_no_req", req_count - req_before, 0);

    // Virtual address wraps past the top of the address space
    send_cmd(64'hFFFF_FFFF_FFFF_FFF8, 32'd16, 1'b1, 1'b0);
    expect_chunk("wrap_c0", 56'hFF_FFFF_FFFF_FFF8, 13'd8, 1'b0, 0);
    expect_chunk("wrap_c1", 56'h0, 13'd8, 1'b1, 0);
    expect_idle("wrap");

    // Async reset mid-command drops everything immediately
    send_cmd(64'h7000, 32'd64, 1'b0, 1'b1);
    expect_req("rstmid", 64'h7000, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstmid_ready", cmd_ready, 1'b1);
    check("rstmid_req", mmu_req, 1'b0);
    check("rstmid_out", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mmu_valid = 1'b1;
    mmu_paddr = 56'h123_4000;
    @(posedge clk);
    #1 mmu_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_no_out_after", out_valid, 1'b0);
    check("rstmid_no_req_after", mmu_req, 1'b0);
    check("rstmid_idle_after", cmd_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
